fetch_stage: RTL and testbench

//  Instruction fetch stage: producer end of the Decode valid/ready interface.
//  - Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
//  - Buffers returned words with their PCs and presents one {pc, instr} per cycle to Decode.
//  - Honours Decode backpressure without losing or duplicating instructions.
//  - Supports redirect (branch/jump/flush), which discards all younger fetched work.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   INSTR_NOP     : canonical no-op encoding (addi x0, x0, 0)
//   align_word()  : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with a single-cycle flush, used to buffer fetch results.
// Wrap-around read/write pointers; count tracks occupancy.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : empties the FIFO at the next edge (push/pop ignored)
//   push,push_data : write one entry at the next edge
//   pop            : remove the head entry at the next edge (ignored if empty)
//   count          : number of stored entries
//   head           : oldest entry, all-zero when empty
// A push while full is accepted only when a pop frees the slot in the same
// cycle; otherwise it is a protocol violation caught by an assertion.
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so full does not block the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  push_into_full_a : assert property (@(posedge clk) disable iff (reset || flush)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, issues word reads to a synchronous
// instruction memory (1-cycle latency), buffers {pc, instr} results and
// presents them to Decode through a valid/ready interface.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   imem_en         : read request this cycle
//   imem_addr       : word-aligned byte address of the request (0 when idle)
//   imem_rdata      : data for the request made the previous cycle
//   redirect_valid  : discard all fetched work and restart at redirect_pc
//   redirect_pc     : new fetch PC (bits [1:0] forced to 0)
//   instr_out       : head instruction to Decode (0 when not valid)
//   pc_out          : head PC to Decode (0 when not valid)
//   valid_out       : head entry is valid
//   ready_in        : Decode accepts the head this cycle
//
// Handshake: a transfer happens in any cycle where valid_out && ready_in.
// valid_out never depends on ready_in, and once valid_out is high the head
// pc/instr hold until that transfer or a redirect/reset.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc_reg;
  logic          inflight;
  logic [31:0]   inflight_pc;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  assign valid_out = (count != '0);
  assign pop       = valid_out && ready_in;

  // Entries held after this edge if nothing new is requested: buffered plus
  // the one returning now, minus the one Decode takes. Keeping this below the
  // depth guarantees every returning word has a slot.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue     = !reset && !redirect_valid && (occupancy < (CW + 1)'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = issue ? pc_reg : '0;

  // A response arriving in a redirect cycle belongs to the old path: drop it.
  assign push      = inflight && !redirect_valid && !reset;
  assign push_data = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc_reg      <= align_word(redirect_pc);
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_reg      <= pc_reg + 32'd4;
        inflight_pc <= pc_reg;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign pc_out    = head.pc;
  assign instr_out = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        reset = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_in = 1'b0;

  // second DUT (RESET_PC = FFFF_FFFC) with a custom word at address 0
  logic        reset2 = 1'b1;
  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic [31:0] instr_out2;
  logic [31:0] pc_out2;
  logic        valid_out2;
  logic        ready2 = 1'b0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instr_out(instr_out2), .pc_out(pc_out2),
    .valid_out(valid_out2), .ready_in(ready2)
  );

  // ---------------- instruction ROM models ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  function automatic logic [31:0] rom2_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hFFF3_0293 : 32'h1000_0000 + a;
  endfunction

  always @(posedge clk) if (imem_en)  imem_rdata  <= rom_word(imem_addr);
  always @(posedge clk) if (imem_en2) imem_rdata2 <= rom2_word(imem_addr2);

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        en;
    logic [31:0] addr;
    logic        vo;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic chk, input logic en,
                     input logic [31:0] addr, input logic vo, input logic [31:0] pc);
    vecs[n_vec] = '{rst, rv, rpc, rdy, chk, en, addr, vo, pc};
    n_vec++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst rv  rpc            rdy chk en  addr           vo  pc
    // reset, then streaming from 0
    add(1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 32'h0);        // c0
    add(0, 0, 32'h0,          1, 1, 1, 32'h0,          0, 32'h0);        // c1
    add(0, 0, 32'h0,          1, 1, 1, 32'h4,          0, 32'h0);        // c2
    add(0, 0, 32'h0,          1, 1, 1, 32'h8,          1, 32'h0);        // c3
    add(0, 0, 32'h0,          1, 1, 1, 32'hC,          1, 32'h4);        // c4
    // backpressure for 6 cycles with head at 0x8
    add(0, 0, 32'h0,          0, 1, 0, 32'h0,          1, 32'h8);        // c5
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,        0, 1, 0, 32'h0,          1, 32'h8);        // c6..c10
    add(0, 0, 32'h0,          1, 1, 1, 32'h10,         1, 32'h8);        // c11
    add(0, 0, 32'h0,          1, 1, 1, 32'h14,         1, 32'hC);        // c12
    add(0, 0, 32'h0,          1, 1, 1, 32'h18,         1, 32'h10);       // c13
    // redirect to 0x100 (head popped in R, in-flight 0x18 dropped)
    add(0, 1, 32'h100,        1, 1, 0, 32'h0,          1, 32'h14);       // c14 R
    add(0, 0, 32'h0,          1, 1, 1, 32'h100,        0, 32'h0);        // c15
    add(0, 0, 32'h0,          1, 1, 1, 32'h104,        0, 32'h0);        // c16
    add(0, 0, 32'h0,          1, 1, 1, 32'h108,        1, 32'h100);      // c17 R+3
    // misaligned redirect target
    add(0, 1, 32'h203,        1, 1, 0, 32'h0,          1, 32'h104);      // c18
    add(0, 0, 32'h0,          1, 1, 1, 32'h200,        0, 32'h0);        // c19
    // back-to-back redirects; last wins, PC wraps
    add(0, 1, 32'h300,        1, 1, 0, 32'h0,          0, 32'h0);        // c20
    add(0, 1, 32'hFFFF_FFFF,  1, 1, 0, 32'h0,          0, 32'h0);        // c21
    add(0, 0, 32'h0,          1, 1, 1, 32'hFFFF_FFFC,  0, 32'h0);        // c22
    add(0, 0, 32'h0,          1, 1, 1, 32'h0,          0, 32'h0);        // c23
    add(0, 0, 32'h0,          1, 1, 1, 32'h4,          1, 32'hFFFF_FFFC);// c24
    add(0, 0, 32'h0,          1, 1, 1, 32'h8,          1, 32'h0);        // c25
    // reset beats a simultaneous redirect
    add(1, 1, 32'h400,        1, 1, 0, 32'h0,          1, 32'h4);        // c26
    add(0, 0, 32'h0,          1, 1, 1, 32'h0,          0, 32'h0);        // c27
    add(0, 0, 32'h0,          1, 1, 1, 32'h4,          0, 32'h0);        // c28
    add(0, 0, 32'h0,          1, 1, 1, 32'h8,          1, 32'h0);        // c29
    add(0, 0, 32'h0,          0, 1, 0, 32'h0,          1, 32'h4);        // c30
    add(0, 0, 32'h0,          0, 1, 0, 32'h0,          1, 32'h4);        // c31
    add(0, 0, 32'h0,          1, 1, 1, 32'hC,          1, 32'h4);        // c32
    add(0, 0, 32'h0,          1, 1, 1, 32'h10,         1, 32'h8);        // c33

    next_cycle();
    for (int i = 0; i < n_vec; i++) begin
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      ready_in       = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check32("imem_en",   i, {31'b0, imem_en},   {31'b0, vecs[i].en});
        check32("imem_addr", i, imem_addr,           vecs[i].addr);
        check32("valid_out", i, {31'b0, valid_out}, {31'b0, vecs[i].vo});
        check32("pc_out",    i, pc_out,              vecs[i].pc);
        check32("instr_out", i, instr_out,
                vecs[i].vo ? rom_word(vecs[i].pc) : 32'h0);
      end
      next_cycle();
    end

    // hand sequence: non-zero RESET_PC wrap and decode of a real word
    reset2 = 1'b1; ready2 = 1'b1;
    next_cycle();
    reset2 = 1'b0;
    #1;
    check32("r2_en0",    0, {31'b0, imem_en2},   32'h1);
    check32("r2_addr0",  0, imem_addr2,          32'hFFFF_FFFC);
    check32("r2_valid0", 0, {31'b0, valid_out2}, 32'h0);
    next_cycle();
    check32("r2_addr1",  1, imem_addr2,          32'h0);
    next_cycle();
    check32("r2_valid2", 2, {31'b0, valid_out2}, 32'h1);
    check32("r2_pc2",    2, pc_out2,             32'hFFFF_FFFC);
    check32("r2_instr2", 2, instr_out2,          32'h0FFF_FFFC);
    next_cycle();
    check32("r2_pc3",    3, pc_out2,             32'h0);
    check32("r2_instr3", 3, instr_out2,          32'hFFF3_0293);
    check32("r2_rd",     3, {27'b0, instr_out2[11:7]},  32'd5);
    check32("r2_rs1",    3, {27'b0, instr_out2[19:15]}, 32'd6);
    check32("r2_imm",    3, {{20{instr_out2[31]}}, instr_out2[31:20]}, 32'hFFFF_FFFF);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
